// File: rtl/keypad_pkg.sv
// Shared keypad definitions: one-hot-low row/column masks, emulator states and the
// index-to-mask helper used by both the scanner and the key-press emulator.
package keypad_pkg;

  localparam logic [3:0] MASK_IDX0    = 4'b0111;
  localparam logic [3:0] MASK_IDX1    = 4'b1011;
  localparam logic [3:0] MASK_IDX2    = 4'b1101;
  localparam logic [3:0] MASK_IDX3    = 4'b1110;
  localparam logic [3:0] COL_RELEASED = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_GAP   = 2'd2
  } emu_state_t;

  // Rows and columns share the same encoding: index 0 drives bit 3 low.
  function automatic logic [3:0] idx_to_mask(input logic [1:0] idx);
    case (idx)
      2'd0:    return MASK_IDX0;
      2'd1:    return MASK_IDX1;
      2'd2:    return MASK_IDX2;
      default: return MASK_IDX3;
    endcase
  endfunction

endpackage

// File: rtl/keypad_row_visit.sv
// Detects the first cycle of a scanner visit to one row: keypadRow matches the mask
// now and did not match on the previous cycle.
module keypad_row_visit
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypadRow,
  input  logic [3:0] mask,
  output logic       visit
);

  logic [3:0] prev_row_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_row_reg <= COL_RELEASED;
    end else begin
      prev_row_reg <= keypadRow;
    end
  end

  // mask is always one-hot-low, so invalid row patterns can never produce a visit
  assign visit = (keypadRow == mask) && (prev_row_reg != mask);

endmodule

// File: rtl/keypad_emu.sv
// Key-press emulator: answers a row-scanning keypad controller as if one key were
// held for req_hold row visits, then released for GAP_VISITS visits.
// Optional macro KEYPAD_EMU_BOUNCE_EN injects contact bounce at the start of a press.
module keypad_emu
  import keypad_pkg::*;
#(
  parameter int GAP_VISITS    = 2,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  keypadRow,
  output logic [3:0]  keypadCol,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_key,
  input  logic [15:0] req_hold,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] GAP_TARGET = 16'(GAP_VISITS);

  emu_state_t  state_reg, state_next;
  logic [3:0]  key_reg, key_next;
  logic [15:0] hold_reg, hold_next;
  logic [15:0] count_reg, count_next;
  logic [3:0]  col_reg, col_next;

  logic [3:0]  row_mask;
  logic [3:0]  col_mask;
  logic        row_hit;
  logic        visit;
  logic        accept;
  logic        bounce_force;
  logic [15:0] hold_eff;
  logic [15:0] count_sat;

  assign row_mask  = idx_to_mask(key_reg[3:2]);
  assign col_mask  = idx_to_mask(key_reg[1:0]);
  assign row_hit   = (keypadRow == row_mask);
  assign accept    = req_valid && (state_reg == ST_IDLE);
  assign hold_eff  = (hold_reg == 16'd0) ? 16'd1 : hold_reg;
  assign count_sat = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;

  keypad_row_visit u_row_visit (
    .clk       (clk),
    .reset     (reset),
    .keypadRow (keypadRow),
    .mask      (row_mask),
    .visit     (visit)
  );

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [15:0] BOUNCE_LIMIT = 16'(BOUNCE_CYCLES);

  logic [15:0] bounce_cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bounce_cnt_reg <= '0;
    end else if (accept) begin
      bounce_cnt_reg <= '0;
    end else if (state_reg == ST_PRESS && bounce_cnt_reg < BOUNCE_LIMIT) begin
      bounce_cnt_reg <= bounce_cnt_reg + 16'd1;
    end
  end

  // Even cycles of the bounce window pull the pressed column back high
  assign bounce_force = (state_reg == ST_PRESS) && (bounce_cnt_reg < BOUNCE_LIMIT) &&
                        !bounce_cnt_reg[0];
`else
  // BOUNCE_CYCLES has no effect in this build
  assign bounce_force = (BOUNCE_CYCLES < 0);
`endif

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    hold_next  = hold_reg;
    count_next = count_reg;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          state_next = ST_PRESS;
          key_next   = req_key;
          hold_next  = req_hold;
          count_next = '0;
        end
      end
      ST_PRESS: begin
        if (count_reg == hold_eff && !row_hit) begin
          state_next = ST_GAP;
          count_next = '0;
        end else if (visit) begin
          count_next = count_sat;
        end
      end
      ST_GAP: begin
        if (GAP_VISITS == 0 || (count_reg == GAP_TARGET && !row_hit)) begin
          state_next = ST_IDLE;
          count_next = '0;
          done       = 1'b1;
        end else if (visit) begin
          count_next = count_sat;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    col_next = COL_RELEASED;
    if (state_reg == ST_PRESS && row_hit && !bounce_force) begin
      col_next = col_mask;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      key_reg   <= '0;
      hold_reg  <= '0;
      count_reg <= '0;
      col_reg   <= COL_RELEASED;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      hold_reg  <= hold_next;
      count_reg <= count_next;
      col_reg   <= col_next;
    end
  end

  assign keypadCol = col_reg;
  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_keypad_emu.sv
// Bench for keypad_emu: per-cycle row traces are generated up front, expected outputs
// are derived from the visit rules by scanning the trace, then the trace is replayed.
module tb_keypad_emu;

  localparam int G = 2;
  localparam int B = 8;
  localparam int N = 2400;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  keypadRow = 4'hF;
  logic [3:0]  keypadCol;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_key = 4'h0;
  logic [15:0] req_hold = 16'h0;
  logic        busy;
  logic        done;

  keypad_emu #(.GAP_VISITS(G), .BOUNCE_CYCLES(B)) dut (
    .clk       (clk),
    .reset     (reset),
    .keypadRow (keypadRow),
    .keypadCol (keypadCol),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_hold  (req_hold),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  logic [3:0]  rows   [N];
  logic [3:0]  col_e  [N];
  logic [3:0]  key_e  [N];
  logic [15:0] hold_e [N];
  bit          busy_e [N];
  bit          done_e [N];
  bit          valid_e[N];

  logic [3:0]  rq_key [4];
  logic [15:0] rq_hold[4];
  int          rq_n;
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_end, m_press_lo, m_press_hi;

  function automatic logic [3:0] olow(input logic [1:0] idx);
    return 4'b1111 ^ (4'b1000 >> idx);
  endfunction

  function automatic bit is_visit(input int t, input logic [3:0] m);
    logic [3:0] p;
    p = (t == 0) ? 4'b1111 : rows[t-1];
    return (rows[t] == m) && (p != m);
  endfunction

  task automatic chk(input string tag, input int t, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, t, got, exp);
    end
  endtask

  // Scanner trace: rows in order with random dwell; optional invalid patterns between
  // rows and in the middle of a dwell.
  task automatic gen_rows(input int lo, input int hi, input int glitch_pct, input int r0);
    int t;
    int r;
    logic [3:0] bad[5];
    bad = '{4'b0000, 4'b1111, 4'b1001, 4'b0011, 4'b0101};
    t = 0;
    r = r0;
    while (t < N) begin
      int d;
      d = $urandom_range(hi, lo);
      for (int k = 0; k < d && t < N; k++) begin
        if (k == d / 2 && k > 0 && $urandom_range(99, 0) < glitch_pct)
          rows[t] = bad[$urandom_range(4, 0)];
        else
          rows[t] = olow(2'(r));
        t++;
      end
      if (t < N && $urandom_range(99, 0) < glitch_pct) begin
        rows[t] = bad[$urandom_range(4, 0)];
        t++;
      end
      r = (r + 1) % 4;
    end
  endtask

  // Expected outputs per cycle. Requests are presented back to back from cycle s and
  // each is held until it is accepted in an idle cycle.
  task automatic build_model(input int s);
    int idle_from, pres, a, vh, pend, gend, gv, cnt, h;
    logic [3:0] rm, cm;
    for (int t = 0; t < N; t++) begin
      col_e[t] = 4'hF; busy_e[t] = 0; done_e[t] = 0;
      valid_e[t] = 0; key_e[t] = 4'h0; hold_e[t] = 16'h0;
    end
    idle_from = 0;
    pres = s;
    m_end = N;
    m_press_lo = 0;
    m_press_hi = 0;
    for (int i = 0; i < rq_n; i++) begin
      a = (pres > idle_from) ? pres : idle_from;
      if (a >= N - 1) break;
      for (int t = pres; t <= a; t++) begin
        valid_e[t] = 1; key_e[t] = rq_key[i]; hold_e[t] = rq_hold[i];
      end
      rm = olow(rq_key[i][3:2]);
      cm = olow(rq_key[i][1:0]);
      h = (rq_hold[i] == 16'd0) ? 1 : int'(rq_hold[i]);
      vh = N; cnt = 0;
      for (int u = a + 1; u < N; u++)
        if (is_visit(u, rm)) begin
          cnt++;
          if (cnt == h) begin vh = u; break; end
        end
      pend = N;
      for (int u = vh; u < N; u++)
        if (rows[u] != rm) begin pend = u; break; end
      gend = N;
      if (pend < N - 1) begin
        if (G == 0) gend = pend + 1;
        else begin
          gv = N; cnt = 0;
          for (int u = pend + 1; u < N; u++)
            if (is_visit(u, rm)) begin
              cnt++;
              if (cnt == G) begin gv = u; break; end
            end
          for (int u = gv; u < N; u++)
            if (rows[u] != rm) begin gend = u; break; end
        end
      end
      for (int u = a + 1; u < N && u <= gend; u++) busy_e[u] = 1;
      if (gend < N) done_e[gend] = 1;
      for (int u = a + 1; u < N - 1 && u <= pend; u++) begin
        if (rows[u] == rm) col_e[u+1] = cm;
`ifdef KEYPAD_EMU_BOUNCE_EN
        if ((u - a - 1) < B && ((u - a - 1) % 2) == 0) col_e[u+1] = 4'hF;
`endif
      end
      if (i == 0) begin m_press_lo = a + 1; m_press_hi = pend; end
      $display("txn %0d key=%b hold=%0d accept@%0d press_end@%0d done@%0d",
               i, rq_key[i], rq_hold[i], a, pend, gend);
      m_end = gend;
      idle_from = gend + 1;
      pres = a + 1;
    end
  endtask

  // Replays the trace after a fresh reset; abort_at >= 0 pulls reset low mid-cycle.
  task automatic run_scn(input int ncyc, input int abort_at);
    reset = 1'b0; req_valid = 1'b0; keypadRow = 4'hF;
    @(negedge clk);
    chk("rst_col", -1, 16'(keypadCol), 16'hF);
    chk("rst_ready", -1, 16'(req_ready), 16'h1);
    chk("rst_busy", -1, 16'(busy), 16'h0);
    chk("rst_done", -1, 16'(done), 16'h0);
    @(posedge clk); #1;
    for (int t = 0; t < ncyc; t++) begin
      keypadRow = rows[t];
      req_valid = valid_e[t];
      req_key   = key_e[t];
      req_hold  = hold_e[t];
      if (t == 0) reset = 1'b1;
      @(negedge clk);
      chk("col", t, 16'(keypadCol), 16'(col_e[t]));
      chk("done", t, 16'(done), 16'(done_e[t]));
      chk("busy", t, 16'(busy), 16'(busy_e[t]));
      chk("ready", t, 16'(req_ready), 16'(!busy_e[t]));
      if (t == abort_at) begin
        #2 reset = 1'b0;
        #1;
        chk("abort_col", t, 16'(keypadCol), 16'hF);
        chk("abort_ready", t, 16'(req_ready), 16'h1);
        chk("abort_busy", t, 16'(busy), 16'h0);
        chk("abort_done", t, 16'(done), 16'h0);
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  function automatic int span();
    return (m_end + 20 < N) ? m_end + 20 : N;
  endfunction

  initial begin
    int ab;

    // Slow scanner, 100 cycles per row: key row 1 / column 2, three visits
    gen_rows(100, 100, 0, 0);
    rq_n = 1; rq_key[0] = 4'b0110; rq_hold[0] = 16'd3;
    build_model(5);
    run_scn(span(), -1);

    // Hold of zero behaves as one visit
    gen_rows(3, 6, 0, int'($urandom_range(3, 0)));
    rq_n = 1; rq_key[0] = 4'b1111; rq_hold[0] = 16'd0;
    build_model(4);
    run_scn(span(), -1);

    // Invalid row patterns scattered through the scan
    gen_rows(4, 8, 40, int'($urandom_range(3, 0)));
    rq_n = 2;
    for (int i = 0; i < 2; i++) begin
      rq_key[i] = 4'($urandom_range(15, 0)); rq_hold[i] = 16'($urandom_range(4, 1));
    end
    build_model(3);
    run_scn(span(), -1);

    // req_valid held through busy: next accept only after done
    gen_rows(2, 5, 10, int'($urandom_range(3, 0)));
    rq_n = 3;
    for (int i = 0; i < 3; i++) begin
      rq_key[i] = 4'($urandom_range(15, 0)); rq_hold[i] = 16'($urandom_range(3, 0));
    end
    build_model(2);
    run_scn(span(), -1);

    // Reset mid-press, picked on a cycle where the column is driven low
    gen_rows(3, 6, 0, int'($urandom_range(3, 0)));
    rq_n = 1; rq_key[0] = 4'($urandom_range(15, 0)); rq_hold[0] = 16'd4;
    build_model(3);
    ab = (m_press_lo + m_press_hi) / 2;
    for (int u = m_press_lo; u <= m_press_hi; u++)
      if (col_e[u] != 4'hF) begin ab = u; break; end
    run_scn(span(), ab);

    // Random requests after the abort
    for (int it = 0; it < 4; it++) begin
      gen_rows(1, 7, 15, int'($urandom_range(3, 0)));
      rq_n = 2;
      for (int i = 0; i < 2; i++) begin
        rq_key[i] = 4'($urandom_range(15, 0)); rq_hold[i] = 16'($urandom_range(5, 0));
      end
      build_model(int'($urandom_range(6, 1)));
      run_scn(span(), -1);
    end

`ifdef KEYPAD_EMU_BOUNCE_EN
    // Row parked on the key row: pressed column bounces, then stays low
    for (int t = 0; t < N; t++) rows[t] = olow(2'd1);
    rq_n = 1; rq_key[0] = 4'b0110; rq_hold[0] = 16'd1;
    build_model(2);
    run_scn(30, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_emu.md
KEYPAD_EMU -- requirements
Module: keypad_emu

Interface
REQ-001 Parameter GAP_VISITS, default 2: key-row visits with columns released after a press, before done.
REQ-002 Parameter BOUNCE_CYCLES, default 8: clock cycles of injected bounce at press start (used only under KEYPAD_EMU_BOUNCE_EN).
REQ-003 clk  input  1  single system clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 keypadRow  input  4  row drive from scanner, one-hot-low (0111, 1011, 1101, 1110 = rows 0..3).
REQ-006 keypadCol  output  4  column return to scanner, active-low, registered.
REQ-007 req_valid  input  1  press request valid.
REQ-008 req_ready  output  1  high exactly when state is IDLE.
REQ-009 req_key  input  4  key code: [3:2] row index, [1:0] column index.
REQ-010 req_hold  input  16  press length in key-row visits; 0 treated as 1.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse at end of release gap.

Function
REQ-013 Request accepted on the rising edge where req_valid and req_ready are both high; req_key and req_hold are latched then and ignored afterwards.
REQ-014 States: IDLE, PRESS, GAP. IDLE->PRESS on accept; PRESS->GAP; GAP->IDLE with done.
REQ-015 Key row mask = one-hot-low of req_key[3:2] (index 0 -> 0111); column mask = one-hot-low of req_key[1:0] (index 0 -> 0111).
REQ-016 Visit: cycle where keypadRow equals key row mask and the previous cycle's keypadRow did not; a visit already in progress at accept does not count.
REQ-017 In PRESS, keypadCol is the column mask on the cycle after any cycle where keypadRow equals the key row mask, else 1111 (one-cycle latency).
REQ-018 PRESS counts visits in a 16-bit counter; once count equals latched hold and keypadRow no longer equals key row mask, go to GAP, counter cleared.
REQ-019 In GAP, keypadCol is 1111; after GAP_VISITS visits and keypadRow leaving key row, pulse done for one cycle and return to IDLE.
REQ-020 GAP_VISITS = 0: GAP lasts exactly one cycle, then done.
REQ-021 Any keypadRow that is not one-hot-low (0000, 1111, multiple lows) yields keypadCol 1111 in the next cycle and counts as no visit.
REQ-022 In IDLE keypadCol is 1111 regardless of keypadRow.
REQ-023 Visit counter saturates at 16'hFFFF; no wrap.
REQ-024 req_valid while busy has no effect; requester holds it until req_ready.

Reset
REQ-025 reset low clears immediately: state IDLE, keypadCol 1111, req_ready 1, busy 0, done 0, counters 0, latched key/hold 0, previous-row register 1111.
REQ-026 Reset mid-PRESS or mid-GAP aborts without done; first accept after reset release behaves as from power-up.

Configuration
REQ-027 Macro KEYPAD_EMU_BOUNCE_EN defined: for the first BOUNCE_CYCLES cycles after PRESS entry, the column bit that would be driven low alternates each cycle starting high, independent of visit counting; afterwards per REQ-017.
REQ-028 Macro undefined: no bounce logic or counter synthesised; behaviour exactly REQ-017.

Structure
REQ-029 Shared package keypad_pkg holds row/column one-hot-low constants, state enum typedef, and 2-bit-index-to-one-hot-low mask function; the keypad scanner shares these.
REQ-030 One sub-module keypad_row_visit: registers previous row, outputs visit pulse for a given mask; instantiated once.

Verification
REQ-031 Scanner model cycles rows every 100 cycles; req_key 4'b0110, hold 3 -> keypadCol 1101 during row 1011 on three visits, then 1111 for two visits, done once, req_ready returns 1.
REQ-032 req_hold 0, req_key 4'b1111 -> exactly one visit of row 1110 returns 1110; done after two further visits.
REQ-033 keypadRow forced 0000 then 1111 during PRESS -> keypadCol 1111 next cycle, visit count unchanged.
REQ-034 reset pulsed low mid-PRESS -> keypadCol 1111 and req_ready 1 asynchronously; no done; new request completes normally.
REQ-035 req_valid held high while busy -> second request accepted only on the cycle after done, no earlier.
REQ-036 KEYPAD_EMU_BOUNCE_EN, BOUNCE_CYCLES 8, row held at key row -> target column toggles 8 cycles, then stays low.
